// File: rtl/ctrl_decode_stage.sv
// ID-stage control unit: decodes the LEGv8 opcode into the ID/EX control register.
// It also detects load-use hazards, handles flushes and counts illegal opcodes.
module ctrl_decode_stage #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned HAZARD_EN = 1,
  parameter int unsigned EN_CBNZ   = 1,
  parameter int unsigned EN_B      = 1,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic [31:0]          instr_i,
  input  logic                 flush_i,
  output logic                 reg2loc_o,
  output logic                 stall_o,
  output logic                 illegal_o,
  output logic                 ex_valid_o,
  output logic                 ex_alusrc_o,
  output logic                 ex_memtoreg_o,
  output logic                 ex_regwrite_o,
  output logic                 ex_memread_o,
  output logic                 ex_memwrite_o,
  output logic                 ex_branch_o,
  output logic [1:0]           ex_aluop_o,
  output logic                 ex_uncond_o,
  output logic                 ex_brnz_o,
  output logic [REG_W-1:0]     ex_rd_o,
  output logic [ILL_CNT_W-1:0] ill_cnt_o
);

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       uncond;
    logic       brnz;
  } ex_ctl_t;

  logic [10:0]    opcode;
  logic           dec_reg2loc;
  ex_ctl_t        dec_ctl;
  logic           dec_match;
  logic           is_cond_br, is_b, is_rtype, is_stur;
  logic           uses_rn, uses_r2;
  logic [REG_W-1:0] rn, r2;
  logic           hazard;

  logic           ex_valid_q, ex_valid_d;
  ex_ctl_t        ex_ctl_q, ex_ctl_d;
  logic [REG_W-1:0]     ex_rd_q, ex_rd_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  assign opcode = instr_i[31:21];

  always_comb begin
    dec_reg2loc = 1'b0;
    dec_ctl     = '0;
    dec_match   = 1'b1;
    is_cond_br  = 1'b0;
    is_b        = 1'b0;
    is_rtype    = 1'b0;
    is_stur     = 1'b0;
    casez (opcode)
      11'b11111000010: dec_ctl = '{alusrc: 1'b1, memtoreg: 1'b1, regwrite: 1'b1,
                                   memread: 1'b1, default: '0};
      11'b11111000000: begin
        is_stur     = 1'b1;
        dec_reg2loc = 1'b1;
        dec_ctl     = '{alusrc: 1'b1, memwrite: 1'b1, default: '0};
      end
      11'b10110100???: begin
        is_cond_br  = 1'b1;
        dec_reg2loc = 1'b1;
        dec_ctl     = '{branch: 1'b1, aluop: 2'b01, default: '0};
      end
      11'b10110101???: begin
        if (EN_CBNZ != 0) begin
          is_cond_br  = 1'b1;
          dec_reg2loc = 1'b1;
          dec_ctl     = '{branch: 1'b1, aluop: 2'b01, brnz: 1'b1, default: '0};
        end else begin
          dec_match = 1'b0;
        end
      end
      11'b000101?????: begin
        if (EN_B != 0) begin
          is_b    = 1'b1;
          dec_ctl = '{branch: 1'b1, aluop: 2'b01, uncond: 1'b1, default: '0};
        end else begin
          dec_match = 1'b0;
        end
      end
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
        is_rtype = 1'b1;
        dec_ctl  = '{regwrite: 1'b1, aluop: 2'b10, default: '0};
      end
      11'b110100101??: begin
        dec_reg2loc = 1'b1;
        dec_ctl     = '{alusrc: 1'b1, regwrite: 1'b1, aluop: 2'b11, default: '0};
      end
      default: dec_match = 1'b0;
    endcase
  end

  assign rn      = instr_i[5 +: REG_W];
  assign r2      = dec_reg2loc ? instr_i[REG_W-1:0] : instr_i[16 +: REG_W];
  assign uses_rn = dec_match & ~is_cond_br & ~is_b;
  assign uses_r2 = is_rtype | is_stur | is_cond_br;

  // XZR as load destination never creates a real dependency.
  assign hazard = (HAZARD_EN != 0) & valid_i & ex_valid_q & ex_ctl_q.memread &
                  (ex_rd_q != REG_W'(31)) &
                  ((uses_rn & (rn == ex_rd_q)) | (uses_r2 & (r2 == ex_rd_q)));

  assign reg2loc_o = valid_i & dec_reg2loc;
  assign stall_o   = hazard & ~flush_i;
  assign illegal_o = valid_i & ~flush_i & ~stall_o & ~dec_match;

  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctl_d   = '0;
    ex_rd_d    = '0;
    if (!flush_i && !stall_o && valid_i && dec_match) begin
      ex_valid_d = 1'b1;
      ex_ctl_d   = dec_ctl;
      ex_rd_d    = instr_i[REG_W-1:0];
    end
  end

  assign ill_cnt_d = (illegal_o && (ill_cnt_q != '1)) ? ill_cnt_q + ILL_CNT_W'(1) : ill_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      ex_ctl_q   <= '0;
      ex_rd_q    <= '0;
      ill_cnt_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctl_q   <= ex_ctl_d;
      ex_rd_q    <= ex_rd_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_alusrc_o   = ex_ctl_q.alusrc;
  assign ex_memtoreg_o = ex_ctl_q.memtoreg;
  assign ex_regwrite_o = ex_ctl_q.regwrite;
  assign ex_memread_o  = ex_ctl_q.memread;
  assign ex_memwrite_o = ex_ctl_q.memwrite;
  assign ex_branch_o   = ex_ctl_q.branch;
  assign ex_aluop_o    = ex_ctl_q.aluop;
  assign ex_uncond_o   = ex_ctl_q.uncond;
  assign ex_brnz_o     = ex_ctl_q.brnz;
  assign ex_rd_o       = ex_rd_q;
  assign ill_cnt_o     = ill_cnt_q;

endmodule
